// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle logic/arith/shift ops plus a shift-add multiplier
// that takes one multiplier bit per cycle. Results are registered with a done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; single-cycle ops complete here
//   MUL   | shift-add multiply in progress, busy high
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [OPRN_WIDTH-1:0] oprn,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  error,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] DW_VAL   = DATA_WIDTH'(DATA_WIDTH);

    localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(9);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  error_q, error_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_err;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic                  shift_big;

    assign shift_big = (op2 >= DW_VAL);

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (oprn)
            OP_ADD: alu_res = op1 + op2;
            OP_SUB: alu_res = op1 - op2;
            OP_AND: alu_res = op1 & op2;
            OP_OR:  alu_res = op1 | op2;
            OP_NOR: alu_res = ~(op1 | op2);
            OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
            OP_SLL: alu_res = shift_big ? '0 : (op1 << op2);
            OP_SRL: alu_res = shift_big ? '0 : (op1 >> op2);
            default: begin
                // Unsupported codes (multiply never reaches this path)
                alu_res = '0;
                alu_err = 1'b1;
            end
        endcase
    end

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        error_d  = error_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (oprn == OP_MUL) begin
                        mcand_d  = op1;
                        mplier_d = op2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        error_d  = alu_err;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = acc_sum;
                    zero_d   = (acc_sum == '0);
                    error_d  = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            error_q  <= error_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign error  = error_q;
    assign done   = done_q;
    assign busy   = (state_q == MUL);

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width in bits (>=4).
REQ-002 Parameter OPRN_WIDTH, default 6, operation code width in bits.
REQ-003 Port CLK input 1: single clock; all state updates on the rising edge.
REQ-004 Port RST input 1: reset, synchronous and active-high.
REQ-005 Port start input 1: request to begin an operation on op1/op2/oprn.
REQ-006 Port oprn input OPRN_WIDTH: operation code, sampled with start.
REQ-007 Port op1 input DATA_WIDTH: first operand, sampled with start.
REQ-008 Port op2 input DATA_WIDTH: second operand, sampled with start.
REQ-009 Port result output DATA_WIDTH: registered result of the last completed operation.
REQ-010 Port zero output 1: registered, high when result == 0.
REQ-011 Port error output 1: registered, high when the last completed oprn was unsupported.
REQ-012 Port busy output 1: high while a multi-cycle operation is in progress.
REQ-013 Port done output 1: one-cycle pulse marking result/zero/error valid.

Function
REQ-014 Opcodes: 0x01 add, 0x02 sub, 0x03 mul, 0x04 and, 0x05 or, 0x06 nor, 0x07 set-less-than, 0x08 shift left, 0x09 shift right; all other values unsupported.
REQ-015 add/sub/mul results truncated to the low DATA_WIDTH bits, wrap-around modulo 2^DATA_WIDTH, no overflow flag.
REQ-016 Set-less-than: result 1 when op1 < op2 (unsigned), else 0.
REQ-017 Shifts: logical, zero fill, amount = op2 as unsigned; amount >= DATA_WIDTH yields 0.
REQ-018 FSM states IDLE and MUL; start is accepted only in IDLE (busy low).
REQ-019 IDLE + start + single-cycle opcode (any except 0x03): result, zero and error update on that edge; done high for the following cycle; state stays IDLE.
REQ-020 IDLE + start + 0x03: operands latched, iteration counter cleared, product accumulator cleared, state -> MUL, busy high from the next cycle.
REQ-021 MUL: shift-add, one multiplier bit per cycle, exactly DATA_WIDTH cycles; on the final iteration edge result/zero/error update, state -> IDLE, busy drops, done high for one cycle.
REQ-022 Mul latency: done visible DATA_WIDTH cycles after the accepting edge; single-cycle ops: 1 cycle.
REQ-023 start while busy is ignored; operands, opcode and the in-flight operation are unaffected.
REQ-024 start in the same cycle done is high is accepted (IDLE); back-to-back single-cycle ops give one result per cycle.
REQ-025 Unsupported opcode: result 0, zero 1, error 1, done pulses after 1 cycle.
REQ-026 Supported opcode completion clears error to 0.
REQ-027 result/zero/error hold their value between completions; done low when no completion.
REQ-028 op1/op2/oprn changes after acceptance have no effect on an in-flight multiply.

Reset
REQ-029 RST high at a rising edge: state IDLE, result 0, zero 1, error 0, busy 0, done 0, counter and accumulator 0.
REQ-030 RST has priority over start and over an in-flight multiply, which is aborted with no done pulse.
REQ-031 start asserted in the same cycle as RST is ignored.

Verification (DATA_WIDTH=32)
REQ-032 start, op1=15, op2=3, oprn=0x01 -> next cycle done=1, result=18, zero=0, error=0, busy=0.
REQ-033 start, op1=10, op2=2, oprn=0x03 -> busy=1 for 32 cycles, done after 32 cycles, result=20; start with 0x01 mid-multiply ignored.
REQ-034 Back-to-back starts: 0x08 (8,2), 0x09 (5,1), 0x08 (1,40), 0x02 (3,5) -> results 32, 2, 0 (zero=1), 0xFFFFFFFE on consecutive cycles.
REQ-035 oprn=0x00 and 0x0A, op1=7, op2=7 -> result 0, zero=1, error=1; following 0x07 (2,4) -> result 1, error=0.
REQ-036 0x03 (0xFFFFFFFF, 2) -> result 0xFFFFFFFE (truncation); 0x06 (15,5) -> 0xFFFFFFF0.
REQ-037 RST at cycle 10 of a multiply -> busy=0, result=0, zero=1, no done; next 0x01 (1,1) -> result 2 after 1 cycle.
